// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: multicycle branch compare (CMP_W bits/cycle, MSB slice first) plus pc+imm target.
// Define BRANCH_EARLY_EXIT_EN to leave CMP on the first differing slice.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CMP_W = 8
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic            beq_i,
   input  logic            bne_i,
   input  logic            blt_i,
   input  logic            bge_i,
   input  logic            bltu_i,
   input  logic            bgeu_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o,
   output logic            pc_write_o,
   output logic            illegal_o
);
   localparam int N  = XLEN / CMP_W;
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam logic [SW-1:0] S_TOP = SW'(N - 1);
   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] s_q;
   logic [XLEN-1:0] rs1_q, rs2_q, target_q;
   logic [5:0] op_q, strb;
   logic eq_q, eq_d, lt_q, lt_d, taken_q, taken_d, illegal_q;
   logic one_hot, signed_op, diff, last;
   logic [CMP_W-1:0] a_sl, b_sl;
   assign strb      = {beq_i, bne_i, blt_i, bge_i, bltu_i, bgeu_i};
   assign one_hot   = (strb != '0) && ((strb & (strb - 6'd1)) == '0);
   assign signed_op = op_q[3] | op_q[2];
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = one_hot ? CMP : DONE;
         CMP:     if (last) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   // Signed compare: flipping the sign bit of the top slice makes unsigned order match signed order.
   always_comb begin
      a_sl = rs1_q[s_q*CMP_W +: CMP_W];
      b_sl = rs2_q[s_q*CMP_W +: CMP_W];
      if (signed_op && s_q == S_TOP) begin
         a_sl[CMP_W-1] = ~a_sl[CMP_W-1];
         b_sl[CMP_W-1] = ~b_sl[CMP_W-1];
      end
   end
   // eq_q doubles as "undecided": only the first differing slice may set lt.
   assign diff = a_sl != b_sl;
   assign eq_d = eq_q & ~diff;
   assign lt_d = (eq_q & diff) ? (a_sl < b_sl) : lt_q;
`ifdef BRANCH_EARLY_EXIT_EN
   assign last = (s_q == '0) || (eq_q && diff);
`else
   assign last = (s_q == '0);
`endif
   assign taken_d = (op_q[5] & eq_d) | (op_q[4] & ~eq_d)
                  | ((op_q[3] | op_q[1]) & lt_d) | ((op_q[2] | op_q[0]) & ~lt_d);
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rs1_q     <= '0;
         rs2_q     <= '0;
         op_q      <= '0;
         target_q  <= '0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
         s_q       <= S_TOP;
         eq_q      <= 1'b1;
         lt_q      <= 1'b0;
      end else if (state_q == IDLE && start_i) begin
         rs1_q     <= rs1_i;
         rs2_q     <= rs2_i;
         op_q      <= strb;
         target_q  <= pc_i + imm_i;
         taken_q   <= 1'b0;
         illegal_q <= ~one_hot;
         s_q       <= S_TOP;
         eq_q      <= 1'b1;
         lt_q      <= 1'b0;
      end else if (state_q == CMP) begin
         eq_q <= eq_d;
         lt_q <= lt_d;
         if (last) taken_q <= taken_d;
         else      s_q <= s_q - 1'b1;
      end
   end
   always_comb begin
      busy_o     = state_q != IDLE;
      done_o     = state_q == DONE;
      pc_write_o = done_o & taken_q;
      taken_o    = taken_q;
      target_o   = target_q;
      illegal_o  = illegal_q;
   end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors for branch_resolve_unit (XLEN=32, CMP_W=8).
module tb_branch_resolve_unit;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic beq = 0, bne = 0, blt = 0, bge = 0, bltu = 0, bgeu = 0;
   logic [31:0] rs1 = 0, rs2 = 0, pc = 0, imm = 0;
   logic busy, done, taken, pc_write, illegal;
   logic [31:0] target;
   int n_chk = 0, n_err = 0;
   localparam int N = 4;
   localparam logic [5:0] BEQ = 6'b100000, BNE = 6'b010000, BLT = 6'b001000;
   localparam logic [5:0] BGE = 6'b000100, BLTU = 6'b000010, BGEU = 6'b000001;

   branch_resolve_unit #(.XLEN(32), .CMP_W(8)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start),
      .beq_i(beq), .bne_i(bne), .blt_i(blt), .bge_i(bge), .bltu_i(bltu), .bgeu_i(bgeu),
      .rs1_i(rs1), .rs2_i(rs2), .pc_i(pc), .imm_i(imm),
      .busy_o(busy), .done_o(done), .taken_o(taken), .target_o(target),
      .pc_write_o(pc_write), .illegal_o(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int k);
`ifdef BRANCH_EARLY_EXIT_EN
      return k + 1;
`else
      return N + 1;
`endif
   endfunction

   task automatic drive(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i);
      {beq, bne, blt, bge, bltu, bgeu} = s;
      rs1 = a; rs2 = b; pc = p; imm = i;
   endtask

   // Returns at the negedge of the done cycle.
   task automatic run(input string tag, input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] i,
                      input logic exp_taken, input logic exp_ill, input int exp_lat);
      int lat;
      @(negedge clk);
      drive(s, a, b, p, i);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      drive(~s, ~a, b ^ 32'h5A5A_5A5A, ~p, ~i);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) check({tag, "_busy1"}, 32'(busy), 32'd1);
         if (done) break;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_taken"}, 32'(taken), 32'(exp_taken));
      check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
      check({tag, "_pcw"}, 32'(pc_write), 32'(exp_taken));
      check({tag, "_target"}, target, p + i);
   endtask

   initial begin
      int dones;
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_taken", 32'(taken), 0);
      check("rst_target", target, 0);
      check("rst_pcw", 32'(pc_write), 0);
      check("rst_illegal", 32'(illegal), 0);
      @(negedge clk) reset = 1'b0;

      run("beq_eq", BEQ, 32'h1234_5678, 32'h1234_5678, 32'h100, 32'h20, 1, 0, 5);
      @(negedge clk);
      check("beq_eq_pulse", 32'(done), 0);
      check("beq_eq_held", 32'(taken), 1);
      check("beq_eq_pcw_pulse", 32'(pc_write), 0);
      run("blt_neg", BLT, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h8, 1, 0, lat_of(1));
      run("bltu_big", BLTU, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h8, 0, 0, lat_of(1));
      run("bgeu_msb", BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h4, 1, 0, lat_of(1));
      run("bge_msb", BGE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h4, 0, 0, lat_of(1));
      run("bne_low", BNE, 32'hA5, 32'hA4, 32'h200, 32'hFFFF_FFFC, 1, 0, 5);
      run("beq_ne", BEQ, 32'h0100_0000, 32'h0200_0000, 32'h10, 32'h10, 0, 0, lat_of(1));
      run("blt_mid", BLT, 32'h0012_0000, 32'h0013_0000, 32'h10, 32'h30, 1, 0, lat_of(2));
      run("ill_two", BEQ | BNE, 32'h5, 32'h5, 32'h300, 32'h4, 0, 1, 1);
      run("ill_zero", 6'b0, 32'h5, 32'h5, 32'h300, 32'h8, 0, 1, 1);
      run("wrap", BEQ, 32'h77, 32'h77, 32'hFFFF_FFF0, 32'h20, 1, 0, 5);
      check("wrap_val", target, 32'h10);

      // Start in the DONE cycle must be dropped.
      run("bgeu_eq", BGEU, 32'h9, 32'h9, 32'h0, 32'h0, 1, 0, 5);
      drive(BNE, 32'h1, 32'h2, 32'h50, 32'h50);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("done_start_busy", 32'(busy), 0);
      check("done_start_done", 32'(done), 0);

      // Starts while busy must neither restart nor queue.
      @(negedge clk);
      drive(BEQ, 32'hCAFE_0001, 32'hCAFE_0001, 32'h1000, 32'h10);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            check("busy_ign_taken", 32'(taken), 1);
            check("busy_ign_target", target, 32'h1010);
         end
         drive(BNE, 32'h1, 32'h2, 32'h0, 32'h0);
         start = (c <= 2);
      end
      start = 1'b0;
      check("busy_ign_dones", 32'(dones), 1);

      // Asynchronous reset mid-compare.
      run("pre_rst", BEQ, 32'h3, 32'h3, 32'h400, 32'h4, 1, 0, 5);
      @(negedge clk);
      drive(BNE, 32'h1111_1111, 32'h1111_1111, 32'h500, 32'h4);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("mid_busy", 32'(busy), 1);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_done", 32'(done), 0);
      check("arst_taken", 32'(taken), 0);
      check("arst_target", target, 0);
      check("arst_pcw", 32'(pc_write), 0);
      check("arst_illegal", 32'(illegal), 0);
      @(negedge clk) reset = 1'b0;
      run("post_rst", BLTU, 32'h1, 32'h2, 32'h600, 32'h40, 1, 0, lat_of(4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
